// File: rtl/cnn_udiv_20ns_11ns_seq.sv
// cnn_udiv_20ns_11ns_seq: radix-2 restoring unsigned divider, one quotient bit per cycle,
// valid/ready handshake on both operand and result sides.
module cnn_udiv_20ns_11ns_seq #(
   parameter int DIVIDEND_WIDTH = 20,
   parameter int DIVISOR_WIDTH  = 11
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero
);
   localparam int DW = DIVIDEND_WIDTH;
   localparam int VW = DIVISOR_WIDTH;
   localparam int CW = $clog2(DIVIDEND_WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_q, state_d;
   logic [DW-1:0] shreg_q, shreg_d, quo_q, quo_d;
   logic [VW-1:0] dvs_q, dvs_d, rmd_q, rmd_d;
   logic [VW:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic zero_q, zero_d, dbz_q, dbz_d;
   logic [VW:0] shifted, rem_nx;
   logic [VW+1:0] trial;
   logic [DW-1:0] q_nx;
   logic ge;
   // Dividend register doubles as quotient register: MSBs shift out, quotient bits shift in.
   assign shifted = {rem_q[VW-1:0], shreg_q[DW-1]};
   assign trial = {1'b0, shifted} - {2'b00, dvs_q};
   assign ge = !trial[VW+1];
   assign rem_nx = ge ? trial[VW:0] : shifted;
   assign q_nx = {shreg_q[DW-2:0], ge};
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      zero_d = zero_q;
      quo_d = quo_q;
      rmd_d = rmd_q;
      dbz_d = dbz_q;
      if (state_q == IDLE && in_valid) begin
         state_d = CALC;
         shreg_d = dividend;
         dvs_d = divisor;
         rem_d = '0;
         cnt_d = CW'(DW - 1);
         zero_d = (divisor == '0);
      end
      if (state_q == CALC) begin
         shreg_d = q_nx;
         rem_d = rem_nx;
         cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
         if (cnt_q == '0) begin
            state_d = DONE;
            quo_d = zero_q ? '1 : q_nx;
            rmd_d = zero_q ? '0 : rem_nx[VW-1:0];
            dbz_d = zero_q;
         end
      end
      if (state_q == DONE && out_ready) state_d = IDLE;
   end
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         zero_q <= 1'b0;
         quo_q <= '0;
         rmd_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
         zero_q <= zero_d;
         quo_q <= quo_d;
         rmd_q <= rmd_d;
         dbz_q <= dbz_d;
      end
   end
   assign in_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient = quo_q;
   assign remainder = rmd_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_cnn_udiv_20ns_11ns_seq.sv
// tb_cnn_udiv_20ns_11ns_seq: table-driven directed checks of the sequential divider,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_cnn_udiv_20ns_11ns_seq;
   logic ap_clk = 1'b0;
   logic ap_rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [19:0] dividend = '0;
   logic [10:0] divisor = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [19:0] quotient;
   logic [10:0] remainder;
   logic div_by_zero;
   int n_pass = 0;
   int n_total = 0;

   cnn_udiv_20ns_11ns_seq dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero));

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [19:0] a;
      logic [10:0] b;
      logic [19:0] q;
      logic [10:0] r;
      logic z;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Returns the number of edges after the acceptance edge until out_valid is seen (nominal 20).
   task automatic do_div(input logic [19:0] a, input logic [10:0] b, input logic rdy, output int lat);
      int w = 0;
      @(negedge ap_clk);
      while (!in_ready && w < 50) begin
         @(negedge ap_clk);
         w++;
      end
      dividend = a;
      divisor = b;
      in_valid = 1'b1;
      out_ready = rdy;
      @(posedge ap_clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge ap_clk);
         #1 lat++;
      end
   endtask

   initial begin
      vec_t vecs[10];
      int lat;
      logic [19:0] hq;
      logic [10:0] hr;
      vecs[0] = '{20'd1000, 11'd7, 20'd142, 11'd6, 1'b0};
      vecs[1] = '{20'd1048575, 11'd2047, 20'd512, 11'd511, 1'b0};
      vecs[2] = '{20'd5, 11'd9, 20'd0, 11'd5, 1'b0};
      vecs[3] = '{20'd0, 11'd1, 20'd0, 11'd0, 1'b0};
      vecs[4] = '{20'd450000, 11'd1500, 20'd300, 11'd0, 1'b0};
      vecs[5] = '{20'd12345, 11'd0, 20'd1048575, 11'd0, 1'b1};
      vecs[6] = '{20'd1048575, 11'd1, 20'd1048575, 11'd0, 1'b0};
      vecs[7] = '{20'd1048575, 11'd2, 20'd524287, 11'd1, 1'b0};
      vecs[8] = '{20'd2047, 11'd2047, 20'd1, 11'd0, 1'b0};
      vecs[9] = '{20'd1234, 11'd10, 20'd123, 11'd4, 1'b0};

      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst quotient", 32'(quotient), 32'd0);
      chk("rst remainder", 32'(remainder), 32'd0);
      chk("rst div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_div(vecs[i].a, vecs[i].b, 1'b1, lat);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'd20);
         chk($sformatf("v%0d quotient", i), 32'(quotient), 32'(vecs[i].q));
         chk($sformatf("v%0d remainder", i), 32'(remainder), 32'(vecs[i].r));
         chk($sformatf("v%0d div_by_zero", i), 32'(div_by_zero), 32'(vecs[i].z));
      end

      // Round trip of the 9x11 product stage.
      for (int i = 0; i < 8; i++) begin
         int a, b;
         a = $urandom_range(511, 0);
         b = $urandom_range(2047, 1);
         do_div(20'(a * b), 11'(b), 1'b1, lat);
         chk($sformatf("rt %0d*%0d quotient", a, b), 32'(quotient), 32'(a));
         chk($sformatf("rt %0d*%0d remainder", a, b), 32'(remainder), 32'd0);
      end

      // Backpressure: result held, new operands ignored.
      do_div(20'd1000, 11'd7, 1'b0, lat);
      chk("bp latency", 32'(lat), 32'd20);
      hq = quotient;
      hr = remainder;
      chk("bp quotient", 32'(hq), 32'd142);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         dividend = 20'(i * 1111 + 3);
         divisor = 11'(i + 2);
         @(posedge ap_clk);
         #1;
         chk("bp out_valid", 32'(out_valid), 32'd1);
         chk("bp in_ready", 32'(in_ready), 32'd0);
         chk("bp quotient hold", 32'(quotient), 32'(hq));
         chk("bp remainder hold", 32'(remainder), 32'(hr));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain in_ready", 32'(in_ready), 32'd1);
      chk("drain quotient kept", 32'(quotient), 32'd142);
      chk("drain remainder kept", 32'(remainder), 32'd6);
      do_div(20'd77, 11'd3, 1'b1, lat);
      chk("77/3 latency", 32'(lat), 32'd20);
      chk("77/3 quotient", 32'(quotient), 32'd25);
      chk("77/3 remainder", 32'(remainder), 32'd2);

      // Reset in the middle of a calculation.
      do_div(20'd0, 11'd0, 1'b1, lat);
      @(negedge ap_clk);
      while (!in_ready) @(negedge ap_clk);
      dividend = 20'd1000;
      divisor = 11'd7;
      in_valid = 1'b1;
      @(posedge ap_clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge ap_clk);
      #1 ap_rst_n = 1'b0;
      #1;
      chk("mid rst out_valid", 32'(out_valid), 32'd0);
      chk("mid rst in_ready", 32'(in_ready), 32'd1);
      chk("mid rst quotient", 32'(quotient), 32'd0);
      chk("mid rst remainder", 32'(remainder), 32'd0);
      chk("mid rst div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (3) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      chk("post rst in_ready", 32'(in_ready), 32'd1);
      do_div(20'd64, 11'd8, 1'b1, lat);
      chk("64/8 latency", 32'(lat), 32'd20);
      chk("64/8 quotient", 32'(quotient), 32'd8);
      chk("64/8 remainder", 32'(remainder), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
